// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - bit-serial unsigned magnitude comparator
// Scans captured operands MSB first, one bit pair per clock, and reports lesser/greater/equal.
module serial_magnitude_comparator #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lesser,
  output logic             greater,
  output logic             equal
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             found_q, found_d;
  logic             gt_q, gt_d;
  logic             done_q, done_d;
  logic             lesser_q, lesser_d;
  logic             greater_q, greater_d;
  logic             equal_q, equal_d;

  logic bit_a;
  logic bit_b;
  logic bit_diff;
  logic last_bit;
  logic rel_found;
  logic rel_gt;

  assign bit_a    = a_q[idx_q];
  assign bit_b    = b_q[idx_q];
  assign bit_diff = bit_a ^ bit_b;
  assign last_bit = (idx_q == '0);

  // Only the most significant difference decides; later differences are ignored.
  assign rel_found = found_q | bit_diff;
  assign rel_gt    = found_q ? gt_q : bit_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      found_q   <= 1'b0;
      gt_q      <= 1'b0;
      done_q    <= 1'b0;
      lesser_q  <= 1'b0;
      greater_q <= 1'b0;
      equal_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      idx_q     <= idx_d;
      found_q   <= found_d;
      gt_q      <= gt_d;
      done_q    <= done_d;
      lesser_q  <= lesser_d;
      greater_q <= greater_d;
      equal_q   <= equal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    idx_d     = idx_q;
    found_d   = found_q;
    gt_d      = gt_q;
    done_d    = 1'b0;
    lesser_d  = lesser_q;
    greater_d = greater_q;
    equal_d   = equal_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d       = a;
          b_d       = b;
          idx_d     = IW'(WIDTH - 1);
          found_d   = 1'b0;
          gt_d      = 1'b0;
          lesser_d  = 1'b0;
          greater_d = 1'b0;
          equal_d   = 1'b0;
          state_d   = COMPARE;
        end
      end

      COMPARE: begin
        idx_d = idx_q - 1'b1;
        if (bit_diff && !found_q) begin
          found_d = 1'b1;
          gt_d    = bit_a;
        end
        if ((EARLY_EXIT && bit_diff) || last_bit) begin
          done_d    = 1'b1;
          greater_d = rel_found & rel_gt;
          lesser_d  = rel_found & ~rel_gt;
          equal_d   = ~rel_found;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == COMPARE);
  assign done    = done_q;
  assign lesser  = lesser_q;
  assign greater = greater_q;
  assign equal   = equal_q;

endmodule
